lcd12864_responder: RTL and testbench
=====================================

Name: lcd12864_responder

Overview:
- ST7920-compatible LCD12864 bus responder: the panel side of the 8-bit parallel RS/RW/E interface.
- Samples host bus transactions on E falling edge and decodes basic-instruction-set commands.
- Maintains a 64-byte DDRAM shadow and answers busy-flag/address reads and data reads.
- Used for on-FPGA panel emulation, HDMI/VGA mirroring via the scan port, and as the checker target for the LCD write driver.

Parameters:
- SYNC_STAGES, 2, synchronizer depth for lcd_en/lcd_rs/lcd_rw/lcd_db_i.
- BUSY_CYCLES, 3600, clk cycles busy after any command or data access (72 us at 50 MHz).
- CLEAR_CYCLES, 80000, clk cycles busy after Clear (1.6 ms at 50 MHz); must be ≥ 64.

Ports:
- clk  in  1  system clock, 50 MHz.
- rstn  in  1  asynchronous active-low reset.
- lcd_rs  in  1  register select, 0 = instruction, 1 = data.
- lcd_rw  in  1  0 = write, 1 = read.
- lcd_en  in  1  enable strobe, asynchronous to clk.
- lcd_db_i  in  8  bus data from host.
- lcd_db_o  out  8  bus data to host during reads.
- lcd_db_oe  out  1  tri-state enable for lcd_db_o.
- rd_addr  in  6  scan-port DDRAM byte address.
- rd_data  out  8  scan-port data; one clk latency.
- disp_on / cursor_on / blink_on  out  1 each  display-control bits D/C/B.
- busy  out  1  internal busy flag.
- wr_pulse  out  1  one-clk pulse per DDRAM byte written by a host data write.
- err_busy  out  1  sticky: a host access arrived while busy.
- err_unsup  out  1  sticky: unsupported or extended-set command received.

Behaviour:
- Reset values: all outputs 0; DDRAM contents 0x20; AC = 0; I/D = 1; RE = 0; DL = 1.
- Bus capture:
  - All bus inputs pass through SYNC_STAGES flops.
  - An event fires on the synchronized E 1→0 transition.
  - rs/rw/data are taken from the same synchronized stage as the E sample that showed 1, i.e. the last high sample.
- AC: 6-bit byte index = {word_addr[4:0], half}, covering DDRAM bytes 0..63.
  - Advances by +1 when I/D = 1, −1 when I/D = 0.
  - Wraps 63→0 and 0→63.
- Write instructions (rs = 0, rw = 0), basic set (RE = 0):
  - 0x01 Clear: AC = 0, I/D = 1; enter FILL.
  - 0x02/0x03 Home: AC = 0.
  - 0x04–0x07 Entry: I/D = bit1; bit0 (shift) is ignored and sets err_unsup.
  - 0x08–0x0F Display: D = bit2, C = bit1, B = bit0.
  - 0x10–0x1F Shift: no effect; sets err_unsup.
  - 0x20–0x3F Function set: DL = bit4, RE = bit2.
  - 0x40–0x7F CGRAM address: no effect; sets err_unsup.
  - 0x80–0xBF Set DDRAM address: AC = {cmd[4:0], 1'b0}. Bit 5 is ignored, so 0x80/0x90/0x88/0x98 select bytes 0/32/16/48.
  - 0xC0–0xFF: no effect; sets err_unsup.
  - RE = 1: only function set is executed; every other command sets err_unsup and is dropped.
  - DL = 0 (4-bit mode) is stored but not implemented; sets err_unsup.
- Data write (rs = 1, rw = 0): DDRAM[AC] = data; pulse wr_pulse; advance AC.
- Status read (rs = 0, rw = 1): lcd_db_o = {busy, 1'b0, AC[5:0]}; no state change.
- Data read (rs = 1, rw = 1): lcd_db_o = DDRAM[AC]; advance AC on the E falling edge.
- lcd_db_oe:
  - Asserts one clk after synchronized E = 1 with rw = 1.
  - Deasserts on the clk after synchronized E = 0.
  - lcd_db_o is registered and holds its value while oe is asserted.
- Busy:
  - Every executed event loads the busy counter: CLEAR_CYCLES for Clear, BUSY_CYCLES otherwise. busy = (counter ≠ 0).
  - An event arriving while busy = 1 sets err_busy and is still executed (lenient mode), then reloads the counter.
  - Status reads never set err_busy and never load the counter.
- FSM states: IDLE, EXEC, FILL.
  - IDLE→EXEC on event.
  - EXEC takes 1 clk, then returns to IDLE, or goes to FILL for Clear.
  - FILL writes 0x20 to bytes 0..63, one per clk (64 clks), then returns to IDLE.
  - An event arriving during FILL is held in a 1-entry pending register and executed on FILL exit.
  - A second event during FILL overwrites the pending entry and sets err_busy.
- Scan port: independent read port; rd_data = DDRAM[rd_addr] registered. During FILL it returns old or new data per byte, with no stall.
- Reset mid-FILL: returns immediately to reset state, with DDRAM contents reset to 0x20.

Decomposition:
- Package lcd12864_pkg:
  - Command opcode masks/values (CLEAR, HOME, ENTRY, DISPLAY, SHIFT, FUNC, CGRAM, DDRAM).
  - Space character 0x20.
  - FSM state enum.
  - Row base words 0x00/0x10/0x08/0x18.
- Sub-module lcd_bus_sync: SYNC_STAGES synchronizer plus E falling-edge detect, emitting ev_valid, ev_rs, ev_rw, ev_data.
- DDRAM is an inferred 64×8 dual-port array inside the top.

Test Plan:
- Init sequence 0x30, 0x30, 0x0C, 0x01, 0x06 -> disp_on = 1, cursor_on = 0, blink_on = 0; busy high for CLEAR_CYCLES after 0x01; AC = 0; all 64 bytes = 0x20 after 64-clk FILL.
- 0x90, then data "1","2","3" -> bytes 32, 33, 34 = 0x31, 0x32, 0x33; three wr_pulse; status read returns 0x00|35 once not busy (0x80|35 while busy).
- 0x04, 0x80, data 0xAA, data 0xBB -> byte 0 = 0xAA, byte 63 = 0xBB (decrement wrap); AC = 62.
- 0x98, 16 data writes, one more write -> bytes 48..63 filled; 17th write lands in byte 0 (wrap); err_busy stays 0 when spacing > BUSY_CYCLES.
- Write 0x01, then a data write "A" 20 clks later -> err_busy = 1; "A" is written to byte 0 after FILL and is not overwritten by the fill.
- Data read after 0x80 on a DDRAM holding 0xE7 at byte 0 -> lcd_db_oe asserted while E high, lcd_db_o = 0xE7, AC = 1 afterwards; rstn pulse mid-FILL -> all outputs 0 and DDRAM = 0x20.

Source files
------------

// File: rtl/lcd12864_pkg.sv
// Shared definitions for the LCD12864 (ST7920) bus responder: opcode masks,
// FSM encoding and DDRAM layout constants.
package lcd12864_pkg;

  localparam logic [7:0] SPACE_CHAR = 8'h20;

  localparam logic [7:0] CMD_CLEAR_MASK   = 8'hFF;
  localparam logic [7:0] CMD_CLEAR_VAL    = 8'h01;
  localparam logic [7:0] CMD_HOME_MASK    = 8'hFE;
  localparam logic [7:0] CMD_HOME_VAL     = 8'h02;
  localparam logic [7:0] CMD_ENTRY_MASK   = 8'hFC;
  localparam logic [7:0] CMD_ENTRY_VAL    = 8'h04;
  localparam logic [7:0] CMD_DISPLAY_MASK = 8'hF8;
  localparam logic [7:0] CMD_DISPLAY_VAL  = 8'h08;
  localparam logic [7:0] CMD_SHIFT_MASK   = 8'hF0;
  localparam logic [7:0] CMD_SHIFT_VAL    = 8'h10;
  localparam logic [7:0] CMD_FUNC_MASK    = 8'hE0;
  localparam logic [7:0] CMD_FUNC_VAL     = 8'h20;
  localparam logic [7:0] CMD_CGRAM_MASK   = 8'hC0;
  localparam logic [7:0] CMD_CGRAM_VAL    = 8'h40;
  localparam logic [7:0] CMD_DDRAM_MASK   = 8'hC0;
  localparam logic [7:0] CMD_DDRAM_VAL    = 8'h80;

  // Word address of the first character of each visible text row.
  localparam logic [4:0] ROW_BASE [4] = '{5'h00, 5'h10, 5'h08, 5'h18};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_FILL = 2'd2
  } state_e;

  function automatic logic op_match(input logic [7:0] cmd, input logic [7:0] mask,
                                    input logic [7:0] val);
    return (cmd & mask) == val;
  endfunction

  function automatic logic [5:0] ac_step(input logic [5:0] ac, input logic inc);
    return inc ? ac + 6'd1 : ac - 6'd1;
  endfunction

endpackage

// File: rtl/lcd_bus_sync.sv
// Synchronizes the asynchronous RS/RW/E/DB bus into clk and emits one event
// per E falling edge carrying the bus values of the last E-high sample.
module lcd_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       lcd_en,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [7:0] lcd_db_i,
  output logic       en_s,
  output logic       rs_s,
  output logic       rw_s,
  output logic       ev_valid,
  output logic       ev_rs,
  output logic       ev_rw,
  output logic [7:0] ev_data
);

  localparam int BW = 11;

  logic [BW-1:0] sync_q [SYNC_STAGES];
  logic [BW-1:0] sync_d [SYNC_STAGES];
  logic [BW-1:0] last_q, last_d;

  always_comb begin
    sync_d[0] = {lcd_en, lcd_rs, lcd_rw, lcd_db_i};
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
    last_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      last_q <= '0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
      last_q <= last_d;
    end
  end

  assign en_s = sync_q[SYNC_STAGES-1][10];
  assign rs_s = sync_q[SYNC_STAGES-1][9];
  assign rw_s = sync_q[SYNC_STAGES-1][8];

  // last_q still holds the final E-high sample when the falling edge is seen.
  assign ev_valid = last_q[10] & ~en_s;
  assign ev_rs    = last_q[9];
  assign ev_rw    = last_q[8];
  assign ev_data  = last_q[7:0];

endmodule

// File: rtl/lcd12864_responder.sv
// Panel-side ST7920 responder: decodes host bus events, keeps a 64-byte DDRAM
// shadow with a scan read port, and models busy timing and the Clear fill.
module lcd12864_responder
  import lcd12864_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int BUSY_CYCLES  = 3600,
  parameter int CLEAR_CYCLES = 80000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_en,
  input  logic [7:0] lcd_db_i,
  output logic [7:0] lcd_db_o,
  output logic       lcd_db_oe,
  input  logic [5:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       busy,
  output logic       wr_pulse,
  output logic       err_busy,
  output logic       err_unsup
);

  localparam int MAX_CYC = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] BUSY_LOAD  = CNT_W'(BUSY_CYCLES);
  localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_CYCLES);

  logic       en_s, rs_s, rw_s;
  logic       ev_valid, ev_rs, ev_rw;
  logic [7:0] ev_data;

  lcd_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .rstn     (rstn),
    .lcd_en   (lcd_en),
    .lcd_rs   (lcd_rs),
    .lcd_rw   (lcd_rw),
    .lcd_db_i (lcd_db_i),
    .en_s     (en_s),
    .rs_s     (rs_s),
    .rw_s     (rw_s),
    .ev_valid (ev_valid),
    .ev_rs    (ev_rs),
    .ev_rw    (ev_rw),
    .ev_data  (ev_data)
  );

  state_e           state_q, state_d;
  logic             pend_vld_q, pend_vld_d;
  logic             pend_rs_q, pend_rs_d, pend_rw_q, pend_rw_d;
  logic [7:0]       pend_data_q, pend_data_d;
  logic             cmd_rs_q, cmd_rs_d, cmd_rw_q, cmd_rw_d;
  logic [7:0]       cmd_data_q, cmd_data_d;
  logic [5:0]       ac_q, ac_d;
  logic             id_q, id_d, re_q, re_d, dl_q, dl_d;
  logic             disp_q, disp_d, cursor_q, cursor_d, blink_q, blink_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]       fill_idx_q, fill_idx_d;
  logic             err_busy_q, err_busy_d, err_unsup_q, err_unsup_d;
  logic             wr_pulse_q, wr_pulse_d;
  logic             oe_q, oe_d;
  logic [7:0]       db_o_q, db_o_d;
  logic [7:0]       rd_data_q;
  logic [7:0]       mem_q [64];
  logic             mem_we;
  logic [5:0]       mem_waddr;
  logic [7:0]       mem_wdata;
  logic             host_ev;

  assign busy = (cnt_q != '0);

  always_comb begin
    state_d     = state_q;
    pend_vld_d  = pend_vld_q;
    pend_rs_d   = pend_rs_q;
    pend_rw_d   = pend_rw_q;
    pend_data_d = pend_data_q;
    cmd_rs_d    = cmd_rs_q;
    cmd_rw_d    = cmd_rw_q;
    cmd_data_d  = cmd_data_q;
    ac_d        = ac_q;
    id_d        = id_q;
    re_d        = re_q;
    dl_d        = dl_q;
    disp_d      = disp_q;
    cursor_d    = cursor_q;
    blink_d     = blink_q;
    cnt_d       = busy ? cnt_q - 1'b1 : cnt_q;
    fill_idx_d  = fill_idx_q;
    err_busy_d  = err_busy_q;
    err_unsup_d = err_unsup_q;
    wr_pulse_d  = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = ac_q;
    mem_wdata   = cmd_data_q;
    // Status reads are answered purely from the bus path and never queue.
    host_ev     = ev_valid & ~(~ev_rs & ev_rw);

    oe_d   = en_s & rw_s;
    db_o_d = db_o_q;
    if (en_s && rw_s && !oe_q) db_o_d = rs_s ? mem_q[ac_q] : {busy, 1'b0, ac_q};

    case (state_q)
      ST_IDLE: begin
        if (pend_vld_q) begin
          cmd_rs_d   = pend_rs_q;
          cmd_rw_d   = pend_rw_q;
          cmd_data_d = pend_data_q;
          pend_vld_d = 1'b0;
          state_d    = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = ST_IDLE;
        cnt_d   = BUSY_LOAD;
        if (cmd_rs_q) begin
          if (!cmd_rw_q) begin
            mem_we     = 1'b1;
            wr_pulse_d = 1'b1;
          end
          ac_d = ac_step(ac_q, id_q);
        end else if (re_q) begin
          if (op_match(cmd_data_q, CMD_FUNC_MASK, CMD_FUNC_VAL)) begin
            dl_d = cmd_data_q[4];
            re_d = cmd_data_q[2];
            if (!cmd_data_q[4]) err_unsup_d = 1'b1;
          end else begin
            err_unsup_d = 1'b1;
          end
        end else if (op_match(cmd_data_q, CMD_CLEAR_MASK, CMD_CLEAR_VAL)) begin
          ac_d       = '0;
          id_d       = 1'b1;
          cnt_d      = CLEAR_LOAD;
          fill_idx_d = '0;
          state_d    = ST_FILL;
        end else if (op_match(cmd_data_q, CMD_HOME_MASK, CMD_HOME_VAL)) begin
          ac_d = '0;
        end else if (op_match(cmd_data_q, CMD_ENTRY_MASK, CMD_ENTRY_VAL)) begin
          id_d = cmd_data_q[1];
          if (cmd_data_q[0]) err_unsup_d = 1'b1;
        end else if (op_match(cmd_data_q, CMD_DISPLAY_MASK, CMD_DISPLAY_VAL)) begin
          disp_d   = cmd_data_q[2];
          cursor_d = cmd_data_q[1];
          blink_d  = cmd_data_q[0];
        end else if (op_match(cmd_data_q, CMD_FUNC_MASK, CMD_FUNC_VAL)) begin
          dl_d = cmd_data_q[4];
          re_d = cmd_data_q[2];
          if (!cmd_data_q[4]) err_unsup_d = 1'b1;
        end else if (op_match(cmd_data_q, CMD_DDRAM_MASK, CMD_DDRAM_VAL)) begin
          ac_d = {cmd_data_q[4:0], 1'b0};
        end else if (op_match(cmd_data_q, CMD_SHIFT_MASK, CMD_SHIFT_VAL) ||
                     op_match(cmd_data_q, CMD_CGRAM_MASK, CMD_CGRAM_VAL)) begin
          err_unsup_d = 1'b1;
        end else begin
          err_unsup_d = 1'b1;
        end
      end
      ST_FILL: begin
        mem_we     = 1'b1;
        mem_waddr  = fill_idx_q;
        mem_wdata  = SPACE_CHAR;
        fill_idx_d = fill_idx_q + 6'd1;
        if (fill_idx_q == 6'd63) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A new event always lands in the pending slot, replacing any older one.
    if (host_ev) begin
      pend_vld_d  = 1'b1;
      pend_rs_d   = ev_rs;
      pend_rw_d   = ev_rw;
      pend_data_d = ev_data;
      if (busy || (pend_vld_q && state_q != ST_IDLE)) err_busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      pend_vld_q  <= 1'b0;
      pend_rs_q   <= 1'b0;
      pend_rw_q   <= 1'b0;
      pend_data_q <= '0;
      cmd_rs_q    <= 1'b0;
      cmd_rw_q    <= 1'b0;
      cmd_data_q  <= '0;
      ac_q        <= '0;
      id_q        <= 1'b1;
      re_q        <= 1'b0;
      dl_q        <= 1'b1;
      disp_q      <= 1'b0;
      cursor_q    <= 1'b0;
      blink_q     <= 1'b0;
      cnt_q       <= '0;
      fill_idx_q  <= '0;
      err_busy_q  <= 1'b0;
      err_unsup_q <= 1'b0;
      wr_pulse_q  <= 1'b0;
      oe_q        <= 1'b0;
      db_o_q      <= '0;
    end else begin
      state_q     <= state_d;
      pend_vld_q  <= pend_vld_d;
      pend_rs_q   <= pend_rs_d;
      pend_rw_q   <= pend_rw_d;
      pend_data_q <= pend_data_d;
      cmd_rs_q    <= cmd_rs_d;
      cmd_rw_q    <= cmd_rw_d;
      cmd_data_q  <= cmd_data_d;
      ac_q        <= ac_d;
      id_q        <= id_d;
      re_q        <= re_d;
      dl_q        <= dl_d;
      disp_q      <= disp_d;
      cursor_q    <= cursor_d;
      blink_q     <= blink_d;
      cnt_q       <= cnt_d;
      fill_idx_q  <= fill_idx_d;
      err_busy_q  <= err_busy_d;
      err_unsup_q <= err_unsup_d;
      wr_pulse_q  <= wr_pulse_d;
      oe_q        <= oe_d;
      db_o_q      <= db_o_d;
    end
  end

  // DDRAM must come back as all spaces on reset, so it is a resettable array.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 64; i++) mem_q[i] <= SPACE_CHAR;
    end else if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rd_data_q <= '0;
    else       rd_data_q <= mem_q[rd_addr];
  end

  assign lcd_db_o  = db_o_q;
  assign lcd_db_oe = oe_q;
  assign rd_data   = rd_data_q;
  assign disp_on   = disp_q;
  assign cursor_on = cursor_q;
  assign blink_on  = blink_q;
  assign wr_pulse  = wr_pulse_q;
  assign err_busy  = err_busy_q;
  assign err_unsup = err_unsup_q;

endmodule

// File: tb/tb_lcd12864_responder.sv
// Bench for lcd12864_responder: command table, directed init/wrap/fill/read
// sequences, and random DDRAM traffic against a simple panel model.
module tb_lcd12864_responder;
  import lcd12864_pkg::*;

  localparam int BUSY_C  = 40;
  localparam int CLEAR_C = 200;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       lcd_rs = 1'b0, lcd_rw = 1'b0, lcd_en = 1'b0;
  logic [7:0] lcd_db_i = 8'h00;
  logic [7:0] lcd_db_o;
  logic       lcd_db_oe;
  logic [5:0] rd_addr = 6'd0;
  logic [7:0] rd_data;
  logic       disp_on, cursor_on, blink_on, busy, wr_pulse, err_busy, err_unsup;

  always #5 clk = ~clk;

  lcd12864_responder #(.SYNC_STAGES(2), .BUSY_CYCLES(BUSY_C), .CLEAR_CYCLES(CLEAR_C)) dut (
    .clk(clk), .rstn(rstn), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en),
    .lcd_db_i(lcd_db_i), .lcd_db_o(lcd_db_o), .lcd_db_oe(lcd_db_oe),
    .rd_addr(rd_addr), .rd_data(rd_data), .disp_on(disp_on), .cursor_on(cursor_on),
    .blink_on(blink_on), .busy(busy), .wr_pulse(wr_pulse), .err_busy(err_busy),
    .err_unsup(err_unsup)
  );

  int total = 0;
  int bad = 0;
  int busy_run = 0;
  int last_run = 0;
  int wr_cnt = 0;

  // Length of the most recent busy window and count of write pulses.
  always @(negedge clk) begin
    if (busy) busy_run++;
    else begin
      if (busy_run != 0) last_run = busy_run;
      busy_run = 0;
    end
    if (wr_pulse) wr_cnt++;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: sim time exceeded, got timeout want finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] cmd;
    logic [2:0] dcb;
    logic       unsup;
    logic [5:0] ac;
  } vec_t;

  vec_t vecs[12];

  byte unsigned ref_mem[64];
  int           ref_ac;
  bit           ref_id;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_cycle(input logic rs, input logic rw, input logic [7:0] d,
                           output logic [7:0] q, output logic oe);
    @(negedge clk);
    lcd_rs = rs; lcd_rw = rw; lcd_db_i = d;
    repeat (2) @(negedge clk);
    lcd_en = 1'b1;
    repeat (6) @(negedge clk);
    q  = lcd_db_o;
    oe = lcd_db_oe;
    lcd_en = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      total++; bad++;
      $display("FAIL wait_idle: busy got 1 want 0");
    end
    @(negedge clk);
  endtask

  task automatic cmd(input logic [7:0] c);
    logic [7:0] q; logic oe;
    bus_cycle(1'b0, 1'b0, c, q, oe);
    wait_idle();
  endtask

  task automatic dat(input logic [7:0] d);
    logic [7:0] q; logic oe;
    bus_cycle(1'b1, 1'b0, d, q, oe);
    wait_idle();
  endtask

  task automatic status(output logic [7:0] s);
    logic oe;
    bus_cycle(1'b0, 1'b1, 8'h00, s, oe);
  endtask

  task automatic scan(input int a, output logic [7:0] q);
    @(negedge clk);
    rd_addr = 6'(a);
    @(negedge clk);
    q = rd_data;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [7:0] q, s;
    logic       oe;
    int         w0, nbad;

    vecs[0]  = '{8'h30, 3'b000, 1'b0, 6'd0};
    vecs[1]  = '{8'h0F, 3'b111, 1'b0, 6'd0};
    vecs[2]  = '{8'h0A, 3'b010, 1'b0, 6'd0};
    vecs[3]  = '{8'h8A, 3'b010, 1'b0, 6'd20};
    vecs[4]  = '{8'h02, 3'b010, 1'b0, 6'd0};
    vecs[5]  = '{8'hB3, 3'b010, 1'b0, 6'd38};
    vecs[6]  = '{8'h0C, 3'b100, 1'b0, 6'd38};
    vecs[7]  = '{8'h34, 3'b100, 1'b0, 6'd38};
    vecs[8]  = '{8'h0F, 3'b100, 1'b1, 6'd38};
    vecs[9]  = '{8'h80, 3'b100, 1'b1, 6'd38};
    vecs[10] = '{8'h30, 3'b100, 1'b1, 6'd38};
    vecs[11] = '{8'h88, 3'b100, 1'b1, 6'd16};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_outputs", {lcd_db_o, lcd_db_oe, rd_data, disp_on, cursor_on, blink_on,
                          busy, wr_pulse, err_busy, err_unsup}, 32'h0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    scan(5, q);     check("rst_ddram", q, 8'h20);
    status(s);      check("rst_status", s, 8'h00);

    // Command table
    for (int i = 0; i < 12; i++) begin
      bus_cycle(1'b0, 1'b0, vecs[i].cmd, q, oe);
      wait_idle();
      check($sformatf("vec%0d_dcb", i), {disp_on, cursor_on, blink_on}, vecs[i].dcb);
      check($sformatf("vec%0d_unsup", i), err_unsup, vecs[i].unsup);
      status(s);
      check($sformatf("vec%0d_ac", i), s, {2'b00, vecs[i].ac});
    end
    check("table_err_busy", err_busy, 1'b0);

    // Init sequence with Clear
    reset_pulse();
    dat(8'h55); dat(8'h66);
    cmd(8'h30); cmd(8'h30); cmd(8'h0C);
    check("busy_len_normal", last_run, BUSY_C);
    bus_cycle(1'b0, 1'b0, 8'h01, q, oe);
    check("clear_busy", busy, 1'b1);
    wait_idle();
    check("busy_len_clear", last_run, CLEAR_C);
    cmd(8'h06);
    check("init_dcb", {disp_on, cursor_on, blink_on}, 3'b100);
    check("init_errs", {err_busy, err_unsup}, 2'b00);
    status(s);      check("init_ac", s, 8'h00);
    for (int a = 0; a < 64; a++) begin
      scan(a, q);   check($sformatf("clear_byte%0d", a), q, 8'h20);
    end

    // Row 2 text and busy status
    w0 = wr_cnt;
    cmd(8'h90);
    dat(8'h31); dat(8'h32);
    bus_cycle(1'b1, 1'b0, 8'h33, q, oe);
    status(s);      check("status_busy", s, 8'hA3);
    check("status_no_err_busy", err_busy, 1'b0);
    wait_idle();
    status(s);      check("status_idle", s, 8'h23);
    check("wr_pulses", wr_cnt - w0, 3);
    scan(32, q);    check("byte32", q, 8'h31);
    scan(33, q);    check("byte33", q, 8'h32);
    scan(34, q);    check("byte34", q, 8'h33);

    // Decrement wrap
    cmd(8'h04); cmd(8'h80); dat(8'hAA); dat(8'hBB);
    scan(0, q);     check("dec_byte0", q, 8'hAA);
    scan(63, q);    check("dec_byte63", q, 8'hBB);
    status(s);      check("dec_ac", s, 8'h3E);
    cmd(8'h06);

    // Increment wrap through the last row
    cmd(8'h98);
    for (int i = 0; i < 16; i++) dat(8'(8'h40 + i));
    dat(8'h7E);
    for (int i = 0; i < 16; i++) begin
      scan(48 + i, q); check($sformatf("row4_byte%0d", 48 + i), q, 8'(8'h40 + i));
    end
    scan(0, q);     check("inc_wrap_byte0", q, 8'h7E);
    check("spaced_err_busy", err_busy, 1'b0);

    // Data write during FILL is held and executed afterwards
    bus_cycle(1'b0, 1'b0, 8'h01, q, oe);
    repeat (12) @(negedge clk);
    bus_cycle(1'b1, 1'b0, 8'h41, q, oe);
    check("fill_err_busy", err_busy, 1'b1);
    wait_idle();
    scan(0, q);     check("fill_pending_byte0", q, 8'h41);
    scan(1, q);     check("fill_byte1", q, 8'h20);
    scan(63, q);    check("fill_byte63", q, 8'h20);
    status(s);      check("fill_pending_ac", s, 8'h01);

    // Data read
    cmd(8'h80); dat(8'hE7); cmd(8'h80);
    bus_cycle(1'b1, 1'b1, 8'h00, q, oe);
    check("read_oe_high", oe, 1'b1);
    check("read_data", q, 8'hE7);
    check("read_oe_released", lcd_db_oe, 1'b0);
    wait_idle();
    status(s);      check("read_ac", s, 8'h01);
    scan(0, q);     check("read_keeps_byte0", q, 8'hE7);

    // Reset in the middle of FILL
    cmd(8'hBF); dat(8'h11); dat(8'h5A);
    scan(63, q);    check("prefill_byte63", q, 8'h5A);
    bus_cycle(1'b0, 1'b0, 8'h01, q, oe);
    repeat (10) @(negedge clk);
    check("midfill_busy", busy, 1'b1);
    rstn = 1'b0;
    @(negedge clk);
    check("midfill_rst_outputs", {lcd_db_o, lcd_db_oe, rd_data, disp_on, cursor_on, blink_on,
                                  busy, wr_pulse, err_busy, err_unsup}, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    nbad = 0;
    for (int a = 0; a < 64; a++) begin
      scan(a, q);
      if (q !== 8'h20) nbad++;
    end
    check("midfill_ddram_nonspace_count", nbad, 0);
    check("midfill_busy_after", busy, 1'b0);
    status(s);      check("midfill_status", s, 8'h00);

    // Random traffic against the panel model
    reset_pulse();
    for (int a = 0; a < 64; a++) ref_mem[a] = 8'h20;
    ref_ac = 0;
    ref_id = 1'b1;
    for (int n = 0; n < 50; n++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op <= 4) begin
        logic [7:0] d;
        d = 8'($urandom);
        dat(d);
        ref_mem[ref_ac] = d;
        ref_ac = ref_id ? (ref_ac + 1) % 64 : (ref_ac + 63) % 64;
      end else if (op == 5) begin
        int row, col, word;
        row  = $urandom_range(0, 3);
        col  = $urandom_range(0, 7);
        word = int'(ROW_BASE[row]) + col;
        cmd(8'(8'h80 + word + ($urandom_range(0, 1) * 32)));
        ref_ac = word * 2;
      end else if (op == 6) begin
        int inc;
        inc = $urandom_range(0, 1);
        cmd(8'(8'h04 + inc * 2));
        ref_id = (inc == 1);
      end else if (op <= 8) begin
        bus_cycle(1'b1, 1'b1, 8'h00, q, oe);
        wait_idle();
        check($sformatf("rnd%0d_read", n), q, ref_mem[ref_ac]);
        ref_ac = ref_id ? (ref_ac + 1) % 64 : (ref_ac + 63) % 64;
      end else begin
        cmd(8'h02);
        ref_ac = 0;
      end
      status(s);
      check($sformatf("rnd%0d_ac", n), s, 8'(ref_ac));
    end
    for (int a = 0; a < 64; a++) begin
      scan(a, q);   check($sformatf("rnd_byte%0d", a), q, ref_mem[a]);
    end
    check("rnd_errs", {err_busy, err_unsup}, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
